// File: rtl/rot_load_pkg.sv
// Shared types and constants for the rotate/load controller.
// Holds the FSM state type and the rotate-count helpers.
package rot_load_pkg;

  localparam int DEPTH_DEF  = 4;
  localparam int MAXROT_DEF = 7;
  localparam int ROT_W      = 3;
  localparam int DATA_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROT
  } state_e;

  function automatic logic [ROT_W-1:0] sat_rot(
    input logic [ROT_W-1:0] r,
    input int               max
  );
    if (int'(r) > max) return ROT_W'(max);
    return r;
  endfunction

endpackage

// File: rtl/rot_load_if.sv
// Upstream word handshake plus downstream shift-register controls.
// master = word source / observer, slave = rot_load_ctrl.
interface rot_load_if #(
  parameter int DEPTH = 4
) ();
  import rot_load_pkg::*;

  logic [DATA_W-1:0]      in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [ROT_W-1:0]       rot_cnt;
  logic [DATA_W-1:0]      load_val;
  logic                   load_en;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   word_done;

  modport master (
    output in_data, in_valid, rot_cnt,
    input  in_ready, load_val, load_en,
    input  busy, fifo_level, word_done
  );

  modport slave (
    input  in_data, in_valid, rot_cnt,
    output in_ready, load_val, load_en,
    output busy, fifo_level, word_done
  );
endinterface

// File: rtl/rot_load_ctrl_fifo.sv
// Small synchronous FIFO with registered storage and occupancy count.
// Pointers wrap naturally since DEPTH is a power of two.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   lvl_q, lvl_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    case ({push, pop})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign level = lvl_q;

endmodule

// File: rtl/rot_load_ctrl.sv
// Feeds queued words into a downstream shift register: one load
// cycle per word, then a per-word number of rotate cycles.
module rot_load_ctrl
  import rot_load_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int MAXROT = MAXROT_DEF
) (
  input logic         clk,
  input logic         rstn,
  rot_load_if.slave   bus
);
  localparam int LW = $clog2(DEPTH) + 1;

  state_e            state_q, state_d;
  logic [ROT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] head;
  logic [LW-1:0]     level;
  logic [ROT_W-1:0]  rot_sat;
  logic              push, pop;
  logic              in_rdy;
  logic              wd;

  assign in_rdy  = !rstn || (level != LW'(DEPTH));
  assign push    = bus.in_valid && in_rdy;
  assign pop     = (state_q == ST_LOAD);
  assign rot_sat = sat_rot(bus.rot_cnt, MAXROT);

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .din   (bus.in_data),
    .dout  (head),
    .level (level)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    wd      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (level != '0) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        last_d = head;
        cnt_d  = rot_sat;
        if (rot_sat == '0) begin
          wd      = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ROT;
        end
      end
      ST_ROT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == ROT_W'(1)) begin
          wd      = 1'b1;
          state_d = (level != '0) ? ST_LOAD : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Reset suppresses the done pulse so an aborted word is never reported.
  assign bus.word_done  = wd && rstn;
  assign bus.load_en    = (state_q == ST_LOAD);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.load_val   = (state_q == ST_LOAD) ? head : last_q;
  assign bus.in_ready   = in_rdy;
  assign bus.fifo_level = level;

endmodule

// File: tb/tb_rot_load_ctrl.sv
// Directed bench for rot_load_ctrl with a rotate-left shift
// register model downstream.
module tb_rot_load_ctrl;
  import rot_load_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  rot_load_if #(.DEPTH(DEPTH)) bus ();

  rot_load_ctrl #(
    .DEPTH  (DEPTH),
    .MAXROT (7)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] sr;
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    if (!rstn)             sr <= 8'h00;
    else if (bus.load_en)  sr <= bus.load_val;
    else if (bus.busy)     sr <= {sr[6:0], sr[7]};
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_load();
    if (exp_q.size() == 0) chk("load_extra", 32'd1, 32'd0);
    else chk("load_val", bus.load_val, exp_q.pop_front());
  endtask

  task automatic trace(input int n, input logic [15:0] le,
                       input logic [15:0] wd, input logic [15:0] bz);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("load_en[%0d]", i), bus.load_en, le[n-1-i]);
      chk($sformatf("word_done[%0d]", i), bus.word_done, wd[n-1-i]);
      chk($sformatf("busy[%0d]", i), bus.busy, bz[n-1-i]);
      if (le[n-1-i]) chk_load();
    end
  endtask

  task automatic push_w(input logic [7:0] d, output int waited);
    bool_ok: begin end
    waited = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      waited++;
    end
    if (waited >= 50) chk("push_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int n, input int budget);
    int loads = 0;
    int cyc = 0;
    while (cyc < budget && !(loads == n && !bus.busy)) begin
      @(negedge clk);
      cyc++;
      if (bus.load_en) begin
        loads++;
        chk_load();
      end
    end
    chk("drain_loads", loads, n);
    chk("drain_idle", bus.busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rstn         = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    bus.rot_cnt  = 3'd0;

    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("rst_level", bus.fifo_level, 0);
      chk("rst_load_en", bus.load_en, 0);
      chk("rst_load_val", bus.load_val, 8'h00);
      chk("rst_in_ready", bus.in_ready, 1);
    end
    tick();
    rstn         = 1'b1;
    bus.in_valid = 1'b0;

    // single word, three rotates: 0x81 rotl 3 -> 0x0C
    tick();
    bus.in_data  = 8'h81;
    bus.rot_cnt  = 3'd3;
    bus.in_valid = 1'b1;
    exp_q.push_back(8'h81);
    tick();
    bus.in_valid = 1'b0;
    trace(6, 16'b010000, 16'b000010, 16'b011110);
    chk("single_sr", sr, 8'h0C);
    chk("single_hold", bus.load_val, 8'h81);

    // back-to-back words, one rotate each
    tick();
    bus.rot_cnt  = 3'd1;
    bus.in_data  = 8'hA5;
    bus.in_valid = 1'b1;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    tick();
    bus.in_data = 8'h3C;
    tick();
    bus.in_valid = 1'b0;
    trace(5, 16'b10100, 16'b01010, 16'b11110);

    // zero rotate
    tick();
    bus.rot_cnt  = 3'd0;
    bus.in_data  = 8'hFF;
    bus.in_valid = 1'b1;
    exp_q.push_back(8'hFF);
    tick();
    bus.in_valid = 1'b0;
    trace(3, 16'b010, 16'b010, 16'b010);
    chk("zero_sr", sr, 8'hFF);

    // full FIFO behind a long-rotating lead word
    tick();
    bus.rot_cnt  = 3'd7;
    bus.in_data  = 8'h99;
    bus.in_valid = 1'b1;
    exp_q.push_back(8'h99);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h55);
    tick();
    bus.in_valid = 1'b0;
    fork
      begin
        tick(); tick(); tick();
        push_w(8'h11, w);
        push_w(8'h22, w);
        push_w(8'h33, w);
        push_w(8'h44, w);
        @(negedge clk);
        chk("full_in_ready", bus.in_ready, 0);
        chk("full_level", bus.fifo_level, 4);
        push_w(8'h55, w);
        chk("full_held", w, 2);
      end
      drain(6, 300);
    join
    chk("order_empty", exp_q.size(), 0);

    // reset during the second rotate cycle with two words queued
    tick();
    bus.rot_cnt  = 3'd5;
    bus.in_data  = 8'hA1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_data = 8'hA2;
    tick();
    bus.in_data = 8'hA3;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_busy", bus.busy, 1);
    chk("mid_load_en", bus.load_en, 0);
    chk("mid_level", bus.fifo_level, 2);
    chk("mid_word_done", bus.word_done, 0);
    tick();
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_level", bus.fifo_level, 0);
    chk("abort_load_val", bus.load_val, 8'h00);
    chk("abort_word_done", bus.word_done, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    tick();
    rstn = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("post_busy", bus.busy, 0);
    chk("post_level", bus.fifo_level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rot_load_ctrl.md
ROT_LOAD_CTRL -- requirements
Module: rot_load_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning input FIFO depth in words (power of two, min 2).
REQ-002 The block SHALL have parameter MAXROT, default 7, meaning maximum rotate cycles per word.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 in_data  input  8  word to be loaded into the downstream shift register.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  FIFO can accept a word.
REQ-008 rot_cnt  input  3  rotate cycles for the word being loaded; sampled in LOAD only.
REQ-009 load_val  output  8  value presented to the downstream shift register.
REQ-010 load_en  output  1  load strobe to the downstream shift register; low means rotate.
REQ-011 busy  output  1  high in LOAD or ROTATE.
REQ-012 fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 word_done  output  1  one-cycle pulse on the last cycle a word is owned.

Function
REQ-014 Push SHALL occur when in_valid and in_ready are both high; in_ready SHALL equal (fifo_level != DEPTH).
REQ-015 The FSM SHALL have states IDLE, LOAD and ROTATE.
REQ-016 IDLE -> LOAD when fifo_level != 0 (pre-update value); otherwise remain in IDLE.
REQ-017 LOAD SHALL last exactly one cycle: load_en=1, load_val=FIFO head, pop one word, latch rot_cnt into rotate counter.
REQ-018 LOAD -> ROTATE if latched rot_cnt != 0; LOAD -> IDLE with word_done=1 if rot_cnt == 0.
REQ-019 ROTATE SHALL hold load_en=0 for exactly rot_cnt cycles, decrementing the counter each cycle.
REQ-020 On the final ROTATE cycle (counter==1) the block SHALL assert word_done and go to LOAD if fifo_level != 0, else IDLE.
REQ-021 load_en and busy SHALL be decoded from the state register only, with no combinational path from any input.
REQ-022 load_val SHALL hold the last loaded word outside LOAD; 0 after reset.
REQ-023 Simultaneous push and pop SHALL leave fifo_level unchanged and preserve FIFO order.
REQ-024 A push into an empty FIFO SHALL be visible to the FSM the following cycle (one-cycle IDLE->LOAD latency minimum).
REQ-025 The FIFO pointers SHALL wrap modulo DEPTH; no overflow or underflow is possible by construction.
REQ-026 rot_cnt values above MAXROT SHALL be saturated to MAXROT.

Reset
REQ-027 While rstn=0 the block SHALL go to IDLE, flush the FIFO (fifo_level=0), clear the rotate counter, and drive load_en=0, load_val=0, busy=0, word_done=0.
REQ-028 in_ready SHALL be 1 during and after reset.
REQ-029 Reset asserted mid-LOAD or mid-ROTATE SHALL abort the word without a word_done pulse.

Structure
REQ-030 Package rot_load_pkg SHALL hold the state enum type, DEPTH/MAXROT defaults and the rotate-count width constant.
REQ-031 The FIFO SHALL be a separate sub-module sync_fifo (push/pop/level, registered storage); the FSM and counter remain in rot_load_ctrl.

Verification
REQ-032 Reset: rstn low 3 cycles with in_valid=1 -> fifo_level=0, load_en=0, load_val=0x00, in_ready=1 throughout.
REQ-033 Single word: push 0x81, rot_cnt=3 -> load_en high one cycle with load_val=0x81, then 3 cycles low, word_done on the 3rd; the downstream register then shows 0x0C.
REQ-034 Back-to-back: push 0xA5, 0x3C with rot_cnt=1 -> LOAD(0xA5), ROTATE, LOAD(0x3C), ROTATE, IDLE; no IDLE cycle between words.
REQ-035 Full FIFO: 5 consecutive pushes with FSM stalled by rot_cnt=7 -> in_ready drops after the 4th accepted word; 5th is held until a pop; order preserved.
REQ-036 Zero rotate: push 0xFF, rot_cnt=0 -> single LOAD cycle with word_done, then IDLE.
REQ-037 Reset mid-ROTATE: rstn low on ROTATE cycle 2 of 5 with 2 words queued -> IDLE, fifo_level=0, no word_done, load_val=0x00.
